// File: rtl/mips_pkg.sv
// Shared fetch-path definitions: PC stage FSM encoding, next-PC source
// select and instruction geometry constants.
package mips_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        SEQ  = 3'd0,
        BR   = 3'd1,
        J    = 3'd2,
        JR   = 3'd3,
        PEND = 3'd4
    } redir_sel_t;

    localparam int INSTR_BYTES = 4;
    localparam int WORD_SHIFT  = 2;

endpackage

// File: rtl/pc_next_stage_if.sv
// Instruction-fetch request bus between the PC stage (master) and
// instruction memory (slave): valid/ready handshake plus the address.
interface pc_next_stage_if #(
    parameter int WIDTH = 32
);
    logic             fetch_valid;
    logic             fetch_ready;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;

    modport master (
        output fetch_valid,
        output pc,
        output pc_plus4,
        input  fetch_ready
    );

    modport slave (
        input  fetch_valid,
        input  pc,
        input  pc_plus4,
        output fetch_ready
    );
endinterface

// File: rtl/pc_target_calc.sv
// Combinational redirect resolution: picks the highest-priority redirect
// (JR > J > branch), forms its target and flags misaligned JR targets,
// which are steered to the exception vector.
module pc_target_calc
    import mips_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h0000_0180
) (
    input  logic             enable_i,
    input  logic [WIDTH-1:0] imm_ext_i,
    input  logic [WIDTH-1:0] branch_pc4_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    input  logic [25:0]      jump_index_i,
    input  logic             jump_reg_i,
    input  logic [WIDTH-1:0] reg_target_i,
    input  logic [WIDTH-1:28] pc_plus4_hi_i,
    output logic             redir_valid_o,
    output redir_sel_t       redir_sel_o,
    output logic [WIDTH-1:0] target_o,
    output logic             misalign_o
);

    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] j_target;
    logic             jr_misaligned;

    assign br_target     = branch_pc4_i + (imm_ext_i << WORD_SHIFT);
    assign j_target      = {pc_plus4_hi_i, jump_index_i, 2'b00};
    assign jr_misaligned = (reg_target_i[1:0] != 2'b00);

    // Priority select of the redirect source and its target address
    always_comb begin
        redir_valid_o = 1'b0;
        redir_sel_o   = SEQ;
        target_o      = '0;
        misalign_o    = 1'b0;
        if (enable_i) begin
            if (jump_reg_i) begin
                redir_valid_o = 1'b1;
                redir_sel_o   = JR;
                target_o      = jr_misaligned ? EXC_VECTOR : reg_target_i;
                misalign_o    = jr_misaligned;
            end else if (jump_i) begin
                redir_valid_o = 1'b1;
                redir_sel_o   = J;
                target_o      = j_target;
            end else if (branch_taken_i) begin
                redir_valid_o = 1'b1;
                redir_sel_o   = BR;
                target_o      = br_target;
            end
        end
    end

endmodule

// File: rtl/pc_next_stage.sv
// Program-counter stage: holds the fetch PC, issues requests over the
// fetch bus and applies redirects immediately when fetch advances or
// parks them in a pending slot until it does.
module pc_next_stage
    import mips_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h0000_0180
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  imm_ext,
    input  logic [WIDTH-1:0]  branch_pc4,
    input  logic              branch_taken,
    input  logic              jump,
    input  logic [25:0]       jump_index,
    input  logic              jump_reg,
    input  logic [WIDTH-1:0]  reg_target,
    input  logic              stall,
    pc_next_stage_if.master   fetch_bus,
    output logic              misalign_exc
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_plus4;
    logic             pend_valid_q, pend_valid_d;
    logic [WIDTH-1:0] pend_target_q, pend_target_d;
    logic             misalign_q;

    logic             fetch_valid;
    logic             advance;
    logic             redir_valid;
    redir_sel_t       redir_sel;
    redir_sel_t       next_sel;
    logic [WIDTH-1:0] redir_target;
    logic             redir_misalign;

    assign pc_plus4    = pc_q + WIDTH'(INSTR_BYTES);
    assign fetch_valid = (state_q != BOOT);
    assign advance     = fetch_valid & fetch_bus.fetch_ready & ~stall;

    assign fetch_bus.fetch_valid = fetch_valid;
    assign fetch_bus.pc          = pc_q;
    assign fetch_bus.pc_plus4    = pc_plus4;
    assign misalign_exc          = misalign_q;

    // Redirects are only honoured once the stage is out of BOOT
    pc_target_calc #(
        .WIDTH      (WIDTH),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_target (
        .enable_i       (state_q != BOOT),
        .imm_ext_i      (imm_ext),
        .branch_pc4_i   (branch_pc4),
        .branch_taken_i (branch_taken),
        .jump_i         (jump),
        .jump_index_i   (jump_index),
        .jump_reg_i     (jump_reg),
        .reg_target_i   (reg_target),
        .pc_plus4_hi_i  (pc_plus4[WIDTH-1:28]),
        .redir_valid_o  (redir_valid),
        .redir_sel_o    (redir_sel),
        .target_o       (redir_target),
        .misalign_o     (redir_misalign)
    );

    // FSM next state: HOLD whenever an issued request is not accepted
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (!advance) state_d = HOLD;
            HOLD:    if (advance)  state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // Next PC and pending-redirect bookkeeping; pc only moves on advance
    always_comb begin
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        if (redir_valid)       next_sel = redir_sel;
        else if (pend_valid_q) next_sel = PEND;
        else                   next_sel = SEQ;

        if (advance) begin
            unique case (next_sel)
                BR, J, JR: pc_d = redir_target;
                PEND:      pc_d = pend_target_q;
                default:   pc_d = pc_plus4;
            endcase
            pend_valid_d = 1'b0;
        end else if (redir_valid) begin
            // A newer redirect simply overwrites an older pending one
            pend_target_d = redir_target;
            pend_valid_d  = 1'b1;
        end
    end

    // Control and architectural PC state, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            pc_q         <= RESET_VECTOR;
            pend_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            misalign_q   <= redir_misalign;
        end
    end

    // Pending target payload; only meaningful while pend_valid_q is set
    always_ff @(posedge clk) begin
        pend_target_q <= pend_target_d;
    end

endmodule

// File: tb/tb_pc_next_stage.sv
// Directed bench for the PC stage: reset, sequential fetch, branch/jump
// targets, pending redirects under stall, priority, misaligned JR,
// back-pressure, wrap-around and asynchronous reset during HOLD.
module tb_pc_next_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] imm_ext;
    logic [31:0] branch_pc4;
    logic        branch_taken;
    logic        jump;
    logic [25:0] jump_index;
    logic        jump_reg;
    logic [31:0] reg_target;
    logic        stall;
    logic        misalign_exc;

    int checks = 0;
    int errors = 0;

    pc_next_stage_if #(.WIDTH(32)) bus ();

    pc_next_stage #(
        .WIDTH        (32),
        .RESET_VECTOR (32'h0000_0000),
        .EXC_VECTOR   (32'h0000_0180)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imm_ext      (imm_ext),
        .branch_pc4   (branch_pc4),
        .branch_taken (branch_taken),
        .jump         (jump),
        .jump_index   (jump_index),
        .jump_reg     (jump_reg),
        .reg_target   (reg_target),
        .stall        (stall),
        .fetch_bus    (bus.master),
        .misalign_exc (misalign_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic jr_to(input logic [31:0] addr);
        jump_reg   = 1'b1;
        reg_target = addr;
        tick();
        jump_reg   = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        imm_ext         = '0;
        branch_pc4      = '0;
        branch_taken    = 1'b0;
        jump            = 1'b0;
        jump_index      = '0;
        jump_reg        = 1'b0;
        reg_target      = '0;
        stall           = 1'b0;
        bus.fetch_ready = 1'b1;

        // Held in reset
        tick();
        tick();
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_valid", {31'b0, bus.fetch_valid}, 32'h0);
        chk("rst_exc", {31'b0, misalign_exc}, 32'h0);

        // Release: BOOT edge, then sequential fetch
        rst_n = 1'b1;
        tick();
        chk("boot_valid", {31'b0, bus.fetch_valid}, 32'h1);
        chk("seq_pc0", bus.pc, 32'h0);
        tick();
        chk("seq_pc4", bus.pc, 32'h4);
        tick();
        chk("seq_pc8", bus.pc, 32'h8);
        tick();
        chk("seq_pc12", bus.pc, 32'hC);
        chk("pc_plus4", bus.pc_plus4, 32'h10);

        // Backward branch: 0x104 + (-2 << 2) = 0xFC
        jr_to(32'h100);
        chk("jr_0x100", bus.pc, 32'h100);
        branch_taken = 1'b1;
        branch_pc4   = 32'h104;
        imm_ext      = 32'hFFFF_FFFE;
        tick();
        branch_taken = 1'b0;
        chk("br_back", bus.pc, 32'hFC);

        // Forward branch: 0x104 + (3 << 2) = 0x110
        jr_to(32'h100);
        branch_taken = 1'b1;
        imm_ext      = 32'h3;
        tick();
        branch_taken = 1'b0;
        chk("br_fwd", bus.pc, 32'h110);

        // Redirects under stall: newest pending (J -> 0x100) wins over branch (0x400)
        jr_to(32'h200);
        chk("jr_0x200", bus.pc, 32'h200);
        stall        = 1'b1;
        branch_taken = 1'b1;
        branch_pc4   = 32'h0;
        imm_ext      = 32'h100;
        tick();
        branch_taken = 1'b0;
        chk("stall1_pc", bus.pc, 32'h200);
        jump       = 1'b1;
        jump_index = 26'h40;
        tick();
        jump = 1'b0;
        chk("stall2_pc", bus.pc, 32'h200);
        chk("stall2_valid", {31'b0, bus.fetch_valid}, 32'h1);
        tick();
        chk("stall3_pc", bus.pc, 32'h200);
        stall = 1'b0;
        tick();
        chk("pend_apply", bus.pc, 32'h100);
        tick();
        chk("pend_cleared", bus.pc, 32'h104);

        // Priority JR > J > branch
        jump_reg     = 1'b1;
        reg_target   = 32'h3000;
        jump         = 1'b1;
        jump_index   = 26'h123;
        branch_taken = 1'b1;
        branch_pc4   = 32'h500;
        imm_ext      = 32'h10;
        tick();
        jump_reg     = 1'b0;
        jump         = 1'b0;
        branch_taken = 1'b0;
        chk("prio_jr", bus.pc, 32'h3000);
        chk("prio_noexc", {31'b0, misalign_exc}, 32'h0);

        // Misaligned JR target -> exception vector, one-cycle pulse
        jr_to(32'h3002);
        chk("mis_pc", bus.pc, 32'h180);
        chk("mis_exc", {31'b0, misalign_exc}, 32'h1);
        tick();
        chk("mis_pc_next", bus.pc, 32'h184);
        chk("mis_exc_clr", {31'b0, misalign_exc}, 32'h0);

        // Back-pressure from instruction memory
        jr_to(32'h40);
        chk("bp_start", bus.pc, 32'h40);
        bus.fetch_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_pc", bus.pc, 32'h40);
            chk("bp_valid", {31'b0, bus.fetch_valid}, 32'h1);
        end
        bus.fetch_ready = 1'b1;
        tick();
        chk("bp_release", bus.pc, 32'h44);

        // Sequential wrap-around
        jr_to(32'hFFFF_FFFC);
        chk("wrap_start", bus.pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap_zero", bus.pc, 32'h0);
        tick();
        chk("wrap_four", bus.pc, 32'h4);

        // Asynchronous reset during HOLD with a pending redirect
        stall      = 1'b1;
        jump_reg   = 1'b1;
        reg_target = 32'h500;
        tick();
        jump_reg = 1'b0;
        chk("hold_pc", bus.pc, 32'h4);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pc", bus.pc, 32'h0);
        chk("async_rst_valid", {31'b0, bus.fetch_valid}, 32'h0);
        stall = 1'b0;
        tick();
        tick();
        chk("rst_hold_pc", bus.pc, 32'h0);

        // Release with a redirect presented during BOOT: must be ignored
        rst_n      = 1'b1;
        jump_reg   = 1'b1;
        reg_target = 32'h700;
        tick();
        jump_reg = 1'b0;
        chk("reboot_valid", {31'b0, bus.fetch_valid}, 32'h1);
        chk("reboot_pc0", bus.pc, 32'h0);
        tick();
        chk("reboot_pc4", bus.pc, 32'h4);
        tick();
        chk("reboot_pc8", bus.pc, 32'h8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
